// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction memory slice: default geometry, NOP encoding
// and the zero-fill helper macro.
`ifndef INSTRUCTION_MEMORY_CLEAR
`define INSTRUCTION_MEMORY_CLEAR
`define CLEAR(width) {(width){1'b0}}
`endif

package instruction_memory_pkg;
    localparam int DEFAULT_WORD_SIZE = 32;
    localparam int DEFAULT_BYTE_SIZE = 8;
    localparam int DEFAULT_MEM_DEPTH = 64;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0000;
endpackage

// File: rtl/instruction_memory_ram_sp_async_read.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module ram_sp_async_read #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0] o_read_data
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Synchronous write port; contents persist across reset.
    always_ff @(posedge i_clk) begin
        if (i_write_enable) begin
            mem_r[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = mem_r[i_read_addr];
endmodule

// File: rtl/instruction_memory.sv
// Byte-serial loaded instruction memory: assembles MSB-first bytes into words and
// serves combinational fetches gated by the stored word count.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int PC_SIZE = 32,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE,
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_clear,
    input  logic                         i_write_enable,
    input  logic [BYTE_SIZE-1:0]         i_byte,
    input  logic [PC_SIZE-1:0]           i_pc,
    output logic [WORD_SIZE-1:0]         o_instruction,
    output logic [$clog2(MEM_DEPTH):0]   o_word_count,
    output logic                         o_byte_pending,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_overflow
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = AW + 1;
    localparam int STAGE_W = WORD_SIZE - BYTE_SIZE;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(MEM_DEPTH);

    logic [CW-1:0]        wr_ptr_r;
    logic [1:0]           byte_cnt_r;
    logic [STAGE_W-1:0]   staging_r;
    logic                 overflow_r;

    logic                 full_s;
    logic                 accept_s;
    logic                 word_done_s;
    logic [WORD_SIZE-1:0] word_s;
    logic [AW-1:0]        rd_index_s;
    logic                 upper_zero_s;
    logic                 hit_s;
    logic [WORD_SIZE-1:0] rd_data_s;
    logic                 unused_pc_low_s;

    assign full_s      = (wr_ptr_r == DEPTH_CNT);
    assign accept_s    = i_write_enable && !full_s && !i_clear && !i_reset;
    assign word_done_s = accept_s && (byte_cnt_r == LAST_BYTE);
    assign word_s      = {staging_r, i_byte};

    // Load-side state: staging shift, word commit, saturating pointer, sticky overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r   <= `CLEAR(CW);
            byte_cnt_r <= 2'd0;
            staging_r  <= `CLEAR(STAGE_W);
            overflow_r <= 1'b0;
        end else if (i_clear) begin
            wr_ptr_r   <= `CLEAR(CW);
            byte_cnt_r <= 2'd0;
            staging_r  <= `CLEAR(STAGE_W);
            overflow_r <= 1'b0;
        end else begin
            if (word_done_s) begin
                wr_ptr_r   <= wr_ptr_r + CW'(1);
                byte_cnt_r <= 2'd0;
                staging_r  <= `CLEAR(STAGE_W);
            end else if (accept_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                staging_r  <= {staging_r[STAGE_W-BYTE_SIZE-1:0], i_byte};
            end
            if (i_write_enable && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    ram_sp_async_read #(
        .DATA_WIDTH(WORD_SIZE),
        .DEPTH     (MEM_DEPTH),
        .ADDR_WIDTH(AW)
    ) u_ram (
        .i_clk         (i_clk),
        .i_write_enable(word_done_s),
        .i_write_addr  (wr_ptr_r[AW-1:0]),
        .i_write_data  (word_s),
        .i_read_addr   (rd_index_s),
        .o_read_data   (rd_data_s)
    );

    // Byte offset within the word is irrelevant to a word fetch.
    assign unused_pc_low_s = ^i_pc[1:0];
    assign rd_index_s      = i_pc[AW+1:2];
    assign upper_zero_s    = (i_pc[PC_SIZE-1:AW+2] == `CLEAR(PC_SIZE-AW-2));
    assign hit_s           = upper_zero_s && ({1'b0, rd_index_s} < wr_ptr_r);

    // Fetch path: anything outside the loaded program reads as NOP.
    always_comb begin
        o_instruction = INSTRUCTION_NOP[WORD_SIZE-1:0];
        if (hit_s) begin
            o_instruction = rd_data_s;
        end else begin
            o_instruction = INSTRUCTION_NOP[WORD_SIZE-1:0];
        end
    end

    assign o_word_count   = wr_ptr_r;
    assign o_byte_pending = (byte_cnt_r != 2'd0);
    assign o_empty        = (wr_ptr_r == `CLEAR(CW));
    assign o_full         = full_s;
    assign o_overflow     = overflow_r;
endmodule
